// File: rtl/eespfal_phase_sequencer.sv
// eespfal_phase_sequencer
//
// Sequences one evaluation of a BIT_SIZE-lane EESPFAL switch datapath:
// latch operands, drive them dual-rail, ramp the per-lane power clocks one
// lane per phase step, sample the dual-rail switch outputs, discharge all
// lanes, then pulse done.
//
// Parameters
//   BIT_SIZE     lane count of the sequenced datapath
//   HOLD_CYCLES  clk_top cycles per phase step and per discharge (1..255)
//
// Ports
//   clk_top                  system clock, rising edge
//   rst_top                  synchronous active-high reset
//   start                    request an evaluation (sampled in IDLE only)
//   abort                    cancel an evaluation during LOAD/EVAL
//   x_in, k_in               single-rail operands
//   s_fb, s_bar_fb           dual-rail switch outputs
//   x_drv/x_bar_drv          dual-rail drive of the latched x operand
//   k_drv/k_bar_drv          dual-rail drive of the latched k operand
//   ph_clk                   per-lane power-clock enables (cumulative)
//   ph_dis                   per-lane discharge enables
//   dis_phase                global discharge strobe
//   busy                     evaluation in progress
//   done                     one-cycle completion pulse
//   s_out, err               sampled result and rail-violation flag
//   aborted                  last evaluation was cancelled

module eespfal_phase_sequencer #(
  parameter int unsigned BIT_SIZE    = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                clk_top,
  input  logic                rst_top,
  input  logic                start,
  input  logic                abort,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  input  logic [BIT_SIZE-1:0] s_fb,
  input  logic [BIT_SIZE-1:0] s_bar_fb,
  output logic [BIT_SIZE-1:0] x_drv,
  output logic [BIT_SIZE-1:0] x_bar_drv,
  output logic [BIT_SIZE-1:0] k_drv,
  output logic [BIT_SIZE-1:0] k_bar_drv,
  output logic [BIT_SIZE-1:0] ph_clk,
  output logic [BIT_SIZE-1:0] ph_dis,
  output logic                dis_phase,
  output logic                busy,
  output logic                done,
  output logic [BIT_SIZE-1:0] s_out,
  output logic                err,
  output logic                aborted
);

  localparam int unsigned    PhW       = (BIT_SIZE > 1) ? $clog2(BIT_SIZE) : 1;
  localparam logic [PhW-1:0] PhaseLast = PhW'(BIT_SIZE - 1);
  // 8 bits covers the full legal HOLD_CYCLES range; counts down to zero.
  localparam logic [7:0]     HoldLast  = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEval,
    StSample,
    StDischarge,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [BIT_SIZE-1:0]  x_q, x_d;
  logic [BIT_SIZE-1:0]  k_q, k_d;
  logic [BIT_SIZE-1:0]  s_out_q, s_out_d;
  logic                 err_q, err_d;
  logic                 aborted_q, aborted_d;

  logic                 step_end;
  logic                 last_phase;

  assign step_end   = (cnt_q == 8'd0);
  assign last_phase = (phase_q == PhaseLast);

  // State register
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      k_q       <= '0;
      s_out_q   <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      k_q       <= k_d;
      s_out_q   <= s_out_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    k_d       = k_q;
    s_out_d   = s_out_q;
    err_d     = err_q;
    aborted_d = aborted_q;

    unique case (state_q)
      StIdle: begin
        // start wins over a simultaneous abort here
        if (start) begin
          state_d   = StLoad;
          x_d       = x_in;
          k_d       = k_in;
          aborted_d = 1'b0;
        end
      end

      StLoad: begin
        cnt_d   = HoldLast;
        phase_d = '0;
        if (abort) begin
          state_d   = StDischarge;
          aborted_d = 1'b1;
        end else begin
          state_d = StEval;
        end
      end

      StEval: begin
        if (abort) begin
          state_d   = StDischarge;
          cnt_d     = HoldLast;
          aborted_d = 1'b1;
        end else if (step_end) begin
          if (last_phase) begin
            state_d = StSample;
          end else begin
            phase_d = phase_q + 1'b1;
            cnt_d   = HoldLast;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StSample: begin
        state_d = StDischarge;
        cnt_d   = HoldLast;
        s_out_d = s_fb;
        // A lane with equal rails has not resolved to a valid dual-rail value.
        err_d   = |(~(s_fb ^ s_bar_fb));
      end

      StDischarge: begin
        if (step_end) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
        phase_d = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = StIdle;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    x_drv     = '0;
    x_bar_drv = '0;
    k_drv     = '0;
    k_bar_drv = '0;
    ph_clk    = '0;
    ph_dis    = '0;
    dis_phase = 1'b0;
    busy      = (state_q != StIdle);
    done      = 1'b0;

    unique case (state_q)
      StLoad, StEval, StSample: begin
        x_drv     = x_q;
        x_bar_drv = ~x_q;
        k_drv     = k_q;
        k_bar_drv = ~k_q;
        if (state_q == StSample) begin
          ph_clk = '1;
        end else if (state_q == StEval) begin
          // Lanes up to and including the current phase stay powered.
          for (int j = 0; j < BIT_SIZE; j++) begin
            ph_clk[j] = (PhW'(j) <= phase_q);
          end
        end
      end
      StDischarge: begin
        ph_dis    = '1;
        dis_phase = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_out   = s_out_q;
  assign err     = err_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_eespfal_phase_sequencer.sv
module tb_eespfal_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, sel;
  logic [3:0] x_in, k_in, s_fb, s_bar_fb;
  logic       start_4, start_1, abort_4, abort_1;

  assign start_4 = start & ~sel;
  assign start_1 = start & sel;
  assign abort_4 = abort & ~sel;
  assign abort_1 = abort & sel;

  logic [3:0] xd4, xbd4, kd4, kbd4, pc4, pd4, so4;
  logic       dp4, bz4, dn4, er4, ab4;
  logic [3:0] xd1, xbd1, kd1, kbd1, pc1, pd1, so1;
  logic       dp1, bz1, dn1, er1, ab1;

  eespfal_phase_sequencer #(.BIT_SIZE(4), .HOLD_CYCLES(4)) dut (
    .clk_top(clk), .rst_top(rst), .start(start_4), .abort(abort_4),
    .x_in(x_in), .k_in(k_in), .s_fb(s_fb), .s_bar_fb(s_bar_fb),
    .x_drv(xd4), .x_bar_drv(xbd4), .k_drv(kd4), .k_bar_drv(kbd4),
    .ph_clk(pc4), .ph_dis(pd4), .dis_phase(dp4), .busy(bz4), .done(dn4),
    .s_out(so4), .err(er4), .aborted(ab4)
  );

  eespfal_phase_sequencer #(.BIT_SIZE(4), .HOLD_CYCLES(1)) dut_h1 (
    .clk_top(clk), .rst_top(rst), .start(start_1), .abort(abort_1),
    .x_in(x_in), .k_in(k_in), .s_fb(s_fb), .s_bar_fb(s_bar_fb),
    .x_drv(xd1), .x_bar_drv(xbd1), .k_drv(kd1), .k_bar_drv(kbd1),
    .ph_clk(pc1), .ph_dis(pd1), .dis_phase(dp1), .busy(bz1), .done(dn1),
    .s_out(so1), .err(er1), .aborted(ab1)
  );

  // Observed outputs of whichever DUT is under test
  logic [3:0] o_xd, o_xbd, o_kd, o_kbd, o_pc, o_pd, o_so;
  logic       o_dp, o_bz, o_dn, o_er, o_ab;
  always_comb begin
    o_xd = sel ? xd1 : xd4;   o_xbd = sel ? xbd1 : xbd4;
    o_kd = sel ? kd1 : kd4;   o_kbd = sel ? kbd1 : kbd4;
    o_pc = sel ? pc1 : pc4;   o_pd  = sel ? pd1 : pd4;
    o_so = sel ? so1 : so4;   o_dp  = sel ? dp1 : dp4;
    o_bz = sel ? bz1 : bz4;   o_dn  = sel ? dn1 : dn4;
    o_er = sel ? er1 : er4;   o_ab  = sel ? ab1 : ab4;
  end

  int tests = 0;
  int fails = 0;

  // Reference state carried between evaluations, per DUT
  logic [3:0] m_s  [2];
  logic       m_err[2];
  logic       m_ab [2];

  function automatic logic rail_err(input logic [3:0] s, input logic [3:0] sb);
    for (int j = 0; j < 4; j++) if (s[j] == sb[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input int c, input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s H%0d cycle T+%0d observed=%h expected=%h",
             tag, sel ? 1 : 4, c, obs, exp);
    end
  endtask

  task automatic check_zero(input int c);
    chk("rst_busy", c, {3'b0, o_bz}, 4'h0);
    chk("rst_done", c, {3'b0, o_dn}, 4'h0);
    chk("rst_phclk", c, o_pc, 4'h0);
    chk("rst_phdis", c, o_pd, 4'h0);
    chk("rst_disph", c, {3'b0, o_dp}, 4'h0);
    chk("rst_drv", c, o_xd | o_xbd | o_kd | o_kbd, 4'h0);
    chk("rst_sout", c, o_so, 4'h0);
    chk("rst_err", c, {3'b0, o_er}, 4'h0);
    chk("rst_abrt", c, {3'b0, o_ab}, 4'h0);
  endtask

  // Expected outputs at cycle T+c of a run started at edge T, from the
  // timeline: LOAD at 1, EVAL 2..1+4H, SAMPLE 2+4H, DISCHARGE H cycles, DONE.
  task automatic check_cycle(input int c, input int h, input logic [3:0] x,
                             input logic [3:0] k, input logic [3:0] s,
                             input logic [3:0] sb, input int a);
    bit         ab     = (a >= 1 && a <= 1 + 4 * h);
    int         samp   = 2 + 4 * h;
    int         dis_s  = ab ? a + 1 : samp + 1;
    int         done_c = dis_s + h;
    bit         live   = (c >= 1 && c <= samp && (!ab || c <= a));
    logic [3:0] e_pc   = 4'h0;
    logic [3:0] e_so   = (!ab && c > samp) ? s : m_s[sel];
    logic       e_er   = (!ab && c > samp) ? rail_err(s, sb) : m_err[sel];
    logic       e_ab   = ab && (c > a);
    for (int j = 0; j < 4; j++) if (live && c >= 2 + j * h) e_pc[j] = 1'b1;
    chk("busy", c, {3'b0, o_bz}, {3'b0, (c >= 1 && c <= done_c)});
    chk("done", c, {3'b0, o_dn}, {3'b0, (c == done_c)});
    chk("ph_clk", c, o_pc, e_pc);
    chk("ph_dis", c, o_pd, (c >= dis_s && c < dis_s + h) ? 4'hF : 4'h0);
    chk("dis_phase", c, {3'b0, o_dp}, {3'b0, (c >= dis_s && c < dis_s + h)});
    chk("x_drv", c, o_xd, live ? x : 4'h0);
    chk("x_bar_drv", c, o_xbd, live ? ~x : 4'h0);
    chk("k_drv", c, o_kd, live ? k : 4'h0);
    chk("k_bar_drv", c, o_kbd, live ? ~k : 4'h0);
    chk("s_out", c, o_so, e_so);
    chk("err", c, {3'b0, o_er}, {3'b0, e_er});
    chk("aborted", c, {3'b0, o_ab}, {3'b0, e_ab});
  endtask

  // Called at a negedge with the selected DUT idle; that cycle is T.
  task automatic run_eval(input logic hs, input logic [3:0] x, input logic [3:0] k,
                          input logic [3:0] s, input logic [3:0] sb, input int a,
                          input int spur_a, input int spur_b);
    int h;
    bit ab;
    int done_c;
    sel      = hs;
    h        = hs ? 1 : 4;
    ab       = (a >= 1 && a <= 1 + 4 * h);
    done_c   = ab ? a + 1 + h : 3 + 5 * h;
    x_in     = x;
    k_in     = k;
    s_fb     = s;
    s_bar_fb = sb;
    start    = 1'b1;
    abort    = (a == 0);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      check_cycle(c, h, x, k, s, sb, a);
      start = (c == spur_a || c == spur_b) && (c <= done_c);
      abort = (c == a);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!ab) begin
      m_s[sel]   = s;
      m_err[sel] = rail_err(s, sb);
    end
    m_ab[sel] = ab;
  endtask

  // H=4 run reset at cycle T+r (with start and abort also high).
  task automatic run_reset(input logic [3:0] x, input logic [3:0] k,
                           input logic [3:0] s, input logic [3:0] sb, input int r);
    sel      = 1'b0;
    x_in     = x;
    k_in     = k;
    s_fb     = s;
    s_bar_fb = sb;
    start    = 1'b1;
    for (int c = 1; c <= r; c++) begin
      @(negedge clk);
      check_cycle(c, 4, x, k, s, sb, -1);
      start = 1'b0;
    end
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    check_zero(r + 1);
    for (int i = 0; i < 2; i++) begin
      m_s[i]   = 4'h0;
      m_err[i] = 1'b0;
      m_ab[i]  = 1'b0;
    end
  endtask

  initial begin
    int h, lim, a, sa, sb_i;
    rst = 1'b1; start = 1'b1; abort = 1'b1; sel = 1'b0;
    x_in = 4'h0; k_in = 4'h0; s_fb = 4'h0; s_bar_fb = 4'h0;
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 4'h0; m_err[i] = 1'b0; m_ab[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    sel = 1'b0; check_zero(0);
    sel = 1'b1; check_zero(0);
    rst = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    @(negedge clk);

    // Directed H=4 runs: clean, lane-2 rail violation, abort, ignored starts
    run_eval(1'b0, 4'b1010, 4'b0110, 4'b1100, 4'b0011, -1, -1, -1);
    run_eval(1'b0, 4'b1010, 4'b0110, 4'b1100, 4'b0111, -1, -1, -1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'b0101, 4'b1010, 7, -1, -1);
    // abort while idle leaves aborted set and does not start anything
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 0, {3'b0, o_bz}, 4'h0);
    chk("idle_abort_flag", 0, {3'b0, o_ab}, 4'h1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), -1, 5, 20);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1, -1, -1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, -1, -1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 18, -1, -1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 20, -1, -1);
    run_eval(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 17, -1, -1);
    run_reset(4'b1010, 4'b0110, 4'b1100, 4'b0011, 9);
    run_eval(1'b0, 4'b0011, 4'b1001, 4'b0110, 4'b1001, -1, -1, -1);

    // Directed H=1 runs
    run_eval(1'b1, 4'b1010, 4'b0110, 4'b1100, 4'b0011, -1, -1, -1);
    run_eval(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 3, -1, -1);
    run_eval(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), -1, 2, 7);

    // Randomized runs on both configurations
    for (int n = 0; n < 24; n++) begin
      sel  = 1'($urandom);
      h    = sel ? 1 : 4;
      lim  = 3 + 5 * h;
      a    = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, lim));
      sa   = int'($urandom_range(1, lim));
      sb_i = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, lim));
      run_eval(sel, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), a, sa, sb_i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
